iiitb_psdm: RTL and testbench

//  Parametrised, run-time programmable serial sequence detector; successor of the fixed 4-bit

---
 rtl/iiitb_psdm.sv | 131 +++++++++++++
 tb/tb_iiitb_psdm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iiitb_psdm.sv
// iiitb_psdm: run-time programmable serial sequence detector.
// A 1..PAT_W bit pattern, its length and an overlap mode are loaded through
// a config strobe. The qualified serial stream is shifted into a history
// register. A match raises a registered one-cycle pulse on detector_out and
// bumps a saturating match counter. All outputs come straight from flops.
module iiitb_psdm #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = $clog2(PAT_W + 1),
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011),
  parameter int               DEF_LEN = 4,
  parameter bit               DEF_OVL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             sequence_in,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] cur_len
);

  // Requested length forced into 1..PAT_W.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == {LEN_W{1'b0}}) begin
      res = LEN_W'(1);
    end else if (len > LEN_W'(PAT_W)) begin
      res = LEN_W'(PAT_W);
    end else begin
      res = len;
    end
    return res;
  endfunction

  // One bit set for every compared position below the active length.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic [CNT_W-1:0] cnt_r;
  logic             det_r;

  logic [LEN_W-1:0] len_clamp_s;
  logic [PAT_W-1:0] hist_n_s;
  logic [LEN_W-1:0] fill_n_s;
  logic             eq_s;
  logic             match_s;
  logic             cnt_sat_s;

  // Clamp the configured length so the stored length is always usable.
  always_comb begin
    len_clamp_s = clamp_len(cfg_len);
  end

  // Candidate history/fill for an accepted bit and the match decision.
  // Bits above the active length are masked out of the compare; fill
  // guarantees that enough fresh bits have arrived since the last clear.
  always_comb begin
    hist_n_s = {hist_r[PAT_W-2:0], sequence_in};
    if (fill_r >= LEN_W'(PAT_W)) begin
      fill_n_s = LEN_W'(PAT_W);
    end else begin
      fill_n_s = fill_r + LEN_W'(1);
    end
    eq_s      = (((hist_n_s ^ pat_r) & len_mask(len_r)) == {PAT_W{1'b0}});
    match_s   = in_valid & ~cfg_we & (fill_n_s >= len_r) & eq_s;
    cnt_sat_s = &cnt_r;
  end

  // Config, history, fill, counter and pulse registers. Reset beats config,
  // config beats an incoming bit (which is then dropped).
  always_ff @(posedge clock) begin
    if (reset) begin
      pat_r  <= DEF_PAT;
      len_r  <= LEN_W'(DEF_LEN);
      ovl_r  <= DEF_OVL;
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {LEN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      det_r  <= 1'b0;
    end else if (cfg_we) begin
      pat_r  <= cfg_pattern;
      len_r  <= len_clamp_s;
      ovl_r  <= cfg_overlap;
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {LEN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      det_r  <= 1'b0;
    end else begin
      det_r <= match_s;
      if (in_valid) begin
        hist_r <= hist_n_s;
        // Non-overlapping mode restarts the fill so the next match needs
        // a full set of fresh bits.
        if (match_s && !ovl_r) begin
          fill_r <= {LEN_W{1'b0}};
        end else begin
          fill_r <= fill_n_s;
        end
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
      if (match_s && !cnt_sat_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign detector_out = det_r;
  assign match_count  = cnt_r;
  assign cur_len      = len_r;

endmodule

// File: tb/tb_iiitb_psdm.sv
// Bench for iiitb_psdm: directed scenarios followed by random traffic, all
// checked against a queue-based model of the received bit stream. A second
// instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_iiitb_psdm;

  localparam int PAT_W  = 8;
  localparam int LEN_W  = $clog2(PAT_W + 1);
  localparam int CNT_W  = 16;
  localparam int SCNT_W = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             sequence_in = 1'b0;

  logic              det, det_s;
  logic [CNT_W-1:0]  cnt;
  logic [SCNT_W-1:0] cnt_s;
  logic [LEN_W-1:0]  cur_len, cur_len_s;

  iiitb_psdm u_dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .sequence_in(sequence_in), .detector_out(det), .match_count(cnt),
    .cur_len(cur_len)
  );

  iiitb_psdm #(.CNT_W(SCNT_W)) u_small (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .sequence_in(sequence_in), .detector_out(det_s), .match_count(cnt_s),
    .cur_len(cur_len_s)
  );

  // Reference model: the bits received since the last clear, oldest first.
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_q[$];
  int               m_cnt, m_cnt_s;
  bit               m_det;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
    m_pat = pat;
    m_len = (len == 0) ? 1 : ((len > PAT_W) ? PAT_W : len);
    m_ovl = ovl;
    m_q.delete();
    m_cnt = 0;
    m_cnt_s = 0;
    m_det = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic cycle(input bit r, input bit we, input logic [PAT_W-1:0] pat,
                       input int len, input bit ovl, input bit v, input bit b);
    bit hit;
    reset = r; cfg_we = we; cfg_pattern = pat; cfg_len = LEN_W'(len);
    cfg_overlap = ovl; in_valid = v; sequence_in = b;
    if (r) begin
      model_clear(PAT_W'(4'b1011), 4, 1'b1);
    end else if (we) begin
      model_clear(pat, len, ovl);
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (hit && (m_q[m_q.size() - 1 - i] != m_pat[i])) hit = 1'b0;
      end
      m_det = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_cnt_s < (1 << SCNT_W) - 1) m_cnt_s++;
        if (!m_ovl) m_q.delete();
      end
    end else begin
      m_det = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    if (det) pulses++;
    check_eq("detector_out", det, m_det);
    check_eq("detector_out_small", det_s, m_det);
    check_eq("match_count", cnt, m_cnt);
    check_eq("match_count_small", cnt_s, m_cnt_s);
    check_eq("cur_len", cur_len, m_len);
  endtask

  // Feed n bits of val, MSB first, with in_valid high.
  task automatic feed(input logic [PAT_W-1:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, val[i]);
  endtask

  initial begin
    logic [PAT_W-1:0] a5;
    @(negedge clock);
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_count", cnt, 0);
    check_eq("reset_len", cur_len, 4);

    // Default 1011 overlapping: pulses after bit 4 and 7.
    pulses = 0;
    feed(8'b0101_1011, 7);
    check_eq("t1_pulses", pulses, 2);
    check_eq("t1_count", cnt, 2);

    // Same stream, non-overlapping: only the first match.
    cycle(1'b0, 1'b1, 8'b0000_1011, 4, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    feed(8'b0101_1011, 7);
    check_eq("t2_pulses", pulses, 1);
    check_eq("t2_count", cnt, 1);

    // Length 0 clamps to 1.
    cycle(1'b0, 1'b1, 8'h01, 0, 1'b1, 1'b0, 1'b0);
    check_eq("t3_len", cur_len, 1);
    pulses = 0;
    feed(8'b0000_1101, 4);
    check_eq("t3_pulses", pulses, 3);
    check_eq("t3_count", cnt, 3);

    // Full-length A5 with idle gaps between valid bits.
    cycle(1'b0, 1'b1, 8'hA5, 8, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, a5[i]);
      if (i % 2 == 1) cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'($urandom));
    end
    check_eq("t4_pulses", pulses, 1);

    // Saturation of the 2-bit counter, then cleared by config.
    cycle(1'b0, 1'b1, 8'h01, 1, 1'b1, 1'b0, 1'b0);
    feed(8'h1F, 5);
    check_eq("t5_small_sat", cnt_s, 3);
    check_eq("t5_count", cnt, 5);
    cycle(1'b0, 1'b1, 8'h01, 1, 1'b1, 1'b0, 1'b0);
    check_eq("t5_small_clr", cnt_s, 0);

    // Reset mid-pattern loses the partial bits; config drops a same-cycle bit.
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    feed(8'b0000_0010, 2);
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b1, 1'b1);
    feed(8'b0000_0011, 2);
    check_eq("t6_pulses", pulses, 0);
    cycle(1'b0, 1'b1, 8'h01, 1, 1'b0, 1'b1, 1'b1);
    check_eq("t6_discard_det", det, 0);
    check_eq("t6_discard_cnt", cnt, 0);

    // Random traffic with occasional reconfiguration and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        cycle(1'b1, 1'($urandom), PAT_W'($urandom), $urandom_range(0, 15),
              1'($urandom), 1'($urandom), 1'($urandom));
      end else if ($urandom_range(0, 49) == 0) begin
        cycle(1'b0, 1'b1, PAT_W'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
              1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        cycle(1'b0, 1'b0, PAT_W'($urandom), 0, 1'b0,
              ($urandom_range(0, 4) != 0), 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
